// File: rtl/pcs_sync_if.sv
//------------------------------------------------------------------------------
// pcs_sync_if : SerDes-side input and aligned code-group output bundle.
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface pcs_sync_if;
  logic [9:0] rx_raw;
  logic       signal_detect;
  logic [9:0] data_10b;
  logic       EVEN;
  logic       sync_status;
  logic [3:0] align_off;

  // master feeds raw words and consumes aligned groups; slave is the aligner
  modport master (
    output rx_raw, signal_detect,
    input  data_10b, EVEN, sync_status, align_off
  );

  modport slave (
    input  rx_raw, signal_detect,
    output data_10b, EVEN, sync_status, align_off
  );
endinterface

`default_nettype wire

// File: rtl/pcs_sync.sv
//------------------------------------------------------------------------------
// pcs_sync : 1000BASE-X comma alignment and code-group synchronization FSM.
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module pcs_sync (
  input  wire logic  clk,
  input  wire logic  reset,
  pcs_sync_if.slave  bus
);

  typedef enum logic [3:0] {
    LOSS_OF_SYNC     = 4'd0,
    COMMA_DETECT_1   = 4'd1,
    ACQUIRE_SYNC_1   = 4'd2,
    COMMA_DETECT_2   = 4'd3,
    ACQUIRE_SYNC_2   = 4'd4,
    COMMA_DETECT_3   = 4'd5,
    SYNC_ACQUIRED_1  = 4'd6,
    SYNC_ACQUIRED_2  = 4'd7,
    SYNC_ACQUIRED_2A = 4'd8,
    SYNC_ACQUIRED_3  = 4'd9,
    SYNC_ACQUIRED_3A = 4'd10,
    SYNC_ACQUIRED_4  = 4'd11,
    SYNC_ACQUIRED_4A = 4'd12
  } state_t;

  localparam logic [6:0] c_COMMA_P = 7'b0011111;
  localparam logic [6:0] c_COMMA_N = 7'b1100000;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_good_cgs;
  logic [1:0]  w_good_cgs_next;

  logic [9:0]  r_prev_raw;
  logic        r_sig;
  logic [9:0]  r_data;
  logic        r_even;
  logic        r_sync;
  logic [3:0]  r_align;

  logic [19:0] w_win;
  logic [9:0]  w_cand [10];
  logic [9:0]  w_is_comma;
  logic        w_found;
  logic [3:0]  w_first;
  logic        w_search;
  logic [3:0]  w_off;
  logic [9:0]  w_group;
  logic        w_comma;
  logic [3:0]  w_tot;
  logic [3:0]  w_hi;
  logic [3:0]  w_lo;
  logic        w_invalid;
  logic        w_e_tog;
  logic        w_cgbad;
  logic        w_even_next;
  logic        w_sync_next;

  function automatic logic [3:0] f_ones(input logic [9:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 10; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // Window spans the previous and current raw word so any bit phase is reachable
  assign w_win = {r_prev_raw, bus.rx_raw};

  generate
    for (genvar k = 0; k < 10; k++) begin : g_cand
      assign w_cand[k]     = w_win[19-k -: 10];
      assign w_is_comma[k] = (w_cand[k][9:3] == c_COMMA_P) ||
                             (w_cand[k][9:3] == c_COMMA_N);
    end
  endgenerate

  always_comb begin
    w_found = 1'b0;
    w_first = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      if (w_is_comma[k]) begin
        w_found = 1'b1;
        w_first = 4'(k);
      end
    end
  end

  // Realignment only happens while hunting; once a comma is seen the phase is frozen
  assign w_search = (r_state == LOSS_OF_SYNC) && r_sig && w_found;
  assign w_off    = w_search ? w_first : r_align;

  always_comb begin
    w_group = 10'd0;
    w_comma = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (w_off == 4'(k)) begin
        w_group = w_cand[k];
        w_comma = w_is_comma[k];
      end
    end
  end

  assign w_tot     = f_ones(w_group);
  assign w_hi      = f_ones({4'b0000, w_group[9:4]});
  assign w_lo      = f_ones({6'b000000, w_group[3:0]});
  assign w_invalid = (w_tot < 4'd4) || (w_tot > 4'd6) ||
                     (w_hi  < 4'd2) || (w_hi  > 4'd4) ||
                     (w_lo  < 4'd1) || (w_lo  > 4'd3);

  assign w_e_tog = ~r_even;
  assign w_cgbad = w_invalid || (w_comma && !w_e_tog);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= LOSS_OF_SYNC;
      r_good_cgs <= 2'd0;
    end else begin
      r_state    <= w_next;
      r_good_cgs <= w_good_cgs_next;
    end
  end

  always_comb begin
    w_next          = r_state;
    w_good_cgs_next = r_good_cgs;
    case (r_state)
      LOSS_OF_SYNC: begin
        if (w_comma) w_next = COMMA_DETECT_1;
      end
      COMMA_DETECT_1: w_next = (!w_invalid && !w_comma) ? ACQUIRE_SYNC_1  : LOSS_OF_SYNC;
      COMMA_DETECT_2: w_next = (!w_invalid && !w_comma) ? ACQUIRE_SYNC_2  : LOSS_OF_SYNC;
      COMMA_DETECT_3: w_next = (!w_invalid && !w_comma) ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
      ACQUIRE_SYNC_1: begin
        // a surviving comma here is necessarily at an even position
        if (w_cgbad)      w_next = LOSS_OF_SYNC;
        else if (w_comma) w_next = COMMA_DETECT_2;
      end
      ACQUIRE_SYNC_2: begin
        if (w_cgbad)      w_next = LOSS_OF_SYNC;
        else if (w_comma) w_next = COMMA_DETECT_3;
      end
      SYNC_ACQUIRED_1: begin
        if (w_cgbad) w_next = SYNC_ACQUIRED_2;
      end
      SYNC_ACQUIRED_2: begin
        if (w_cgbad) begin
          w_next = SYNC_ACQUIRED_3;
        end else begin
          w_next          = SYNC_ACQUIRED_2A;
          w_good_cgs_next = 2'd1;
        end
      end
      SYNC_ACQUIRED_3: begin
        if (w_cgbad) begin
          w_next = SYNC_ACQUIRED_4;
        end else begin
          w_next          = SYNC_ACQUIRED_3A;
          w_good_cgs_next = 2'd1;
        end
      end
      SYNC_ACQUIRED_4: begin
        if (w_cgbad) begin
          w_next = LOSS_OF_SYNC;
        end else begin
          w_next          = SYNC_ACQUIRED_4A;
          w_good_cgs_next = 2'd1;
        end
      end
      SYNC_ACQUIRED_2A: begin
        if (w_cgbad) begin
          w_next          = SYNC_ACQUIRED_3;
          w_good_cgs_next = 2'd0;
        end else if (r_good_cgs == 2'd3) begin
          w_next          = SYNC_ACQUIRED_1;
          w_good_cgs_next = 2'd0;
        end else begin
          w_good_cgs_next = r_good_cgs + 2'd1;
        end
      end
      SYNC_ACQUIRED_3A: begin
        if (w_cgbad) begin
          w_next          = SYNC_ACQUIRED_4;
          w_good_cgs_next = 2'd0;
        end else if (r_good_cgs == 2'd3) begin
          w_next          = SYNC_ACQUIRED_2;
          w_good_cgs_next = 2'd0;
        end else begin
          w_good_cgs_next = r_good_cgs + 2'd1;
        end
      end
      SYNC_ACQUIRED_4A: begin
        if (w_cgbad) begin
          w_next          = LOSS_OF_SYNC;
          w_good_cgs_next = 2'd0;
        end else if (r_good_cgs == 2'd3) begin
          w_next          = SYNC_ACQUIRED_3;
          w_good_cgs_next = 2'd0;
        end else begin
          w_good_cgs_next = r_good_cgs + 2'd1;
        end
      end
      default: begin
        w_next          = LOSS_OF_SYNC;
        w_good_cgs_next = 2'd0;
      end
    endcase

    // losing the PMD signal overrides every other transition
    if (!r_sig) begin
      w_next          = LOSS_OF_SYNC;
      w_good_cgs_next = 2'd0;
    end
  end

  assign w_even_next = (w_next == COMMA_DETECT_1) || (w_next == COMMA_DETECT_2) ||
                       (w_next == COMMA_DETECT_3) || w_e_tog;
  assign w_sync_next = w_next inside {SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_2A,
                                      SYNC_ACQUIRED_3, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4,
                                      SYNC_ACQUIRED_4A};

  // signal_detect is delayed with the raw word so it qualifies the same group
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_raw <= 10'd0;
      r_sig      <= 1'b0;
      r_data     <= 10'd0;
      r_even     <= 1'b0;
      r_sync     <= 1'b0;
      r_align    <= 4'd0;
    end else begin
      r_prev_raw <= bus.rx_raw;
      r_sig      <= bus.signal_detect;
      r_data     <= w_group;
      r_even     <= w_even_next;
      r_sync     <= w_sync_next;
      r_align    <= w_off;
    end
  end

  assign bus.data_10b    = r_data;
  assign bus.EVEN        = r_even;
  assign bus.sync_status = r_sync;
  assign bus.align_off   = r_align;

endmodule

`default_nettype wire
